// File: rtl/text_frame_buffer.sv
// Text-mode frame buffer: raster position -> {code_point, attribute} cell plus cursor flag, 2-cycle read latency.
// Host writes use valid/ready and only stall while a hardware clear is starting or running.
module text_frame_buffer #(
  parameter int    COLS                = 160,
  parameter int    ROWS                = 45,
  parameter int    GLYPH_W             = 8,
  parameter int    GLYPH_H             = 16,
  parameter int    CURSOR_BLINK_FRAMES = 30,
  parameter string INIT_FILE           = ""
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [10:0]                hcount_in,
  input  logic [9:0]                 vcount_in,
  input  logic                       active_draw_in,
  input  logic                       frame_start_in,
  input  logic [$clog2(ROWS)-1:0]    scroll_row_in,
  input  logic                       cursor_en_in,
  input  logic [$clog2(COLS)-1:0]    cursor_col_in,
  input  logic [$clog2(ROWS)-1:0]    cursor_row_in,
  input  logic                       wr_valid_in,
  output logic                       wr_ready_out,
  input  logic [$clog2(COLS)-1:0]    wr_col_in,
  input  logic [$clog2(ROWS)-1:0]    wr_row_in,
  input  logic [15:0]                wr_data_in,
  output logic                       wr_err_out,
  input  logic                       clear_in,
  input  logic [15:0]                clear_data_in,
  output logic                       busy_out,
  output logic                       valid_out,
  output logic [$clog2(GLYPH_W)-1:0] x_out,
  output logic [$clog2(GLYPH_H)-1:0] y_out,
  output logic [7:0]                 code_point_out,
  output logic [7:0]                 attribute_out,
  output logic                       cursor_out
);
  localparam int RW    = $clog2(ROWS);
  localparam int XW    = $clog2(GLYPH_W);
  localparam int YW    = $clog2(GLYPH_H);
  localparam int SCW   = 11 - XW;
  localparam int SRW   = 10 - YW;
  localparam int MW    = ((SRW > RW) ? SRW : RW) + 1;
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (CURSOR_BLINK_FRAMES > 1) ? $clog2(CURSOR_BLINK_FRAMES) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q;
  logic            busy_q;
  logic [AW-1:0]   clr_addr_q;
  logic [15:0]     clr_data_q;
  logic            wr_err_q;
  logic [RW-1:0]   scroll_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            phase_q;

  logic [15:0]     mem [DEPTH];
  logic [15:0]     rd_q;
  logic            ok1_q, cur1_q;
  logic [XW-1:0]   x1_q, x_q;
  logic [YW-1:0]   y1_q, y_q;
  logic            valid_q, cursor_q;
  logic [7:0]      code_q, attr_q;

  // Read address: screen cell -> memory cell with row scroll folded in by one conditional subtract
  logic [SCW-1:0]  scol_d;
  logic [SRW-1:0]  srow_d;
  logic            cell_ok_d, cur_hit_d;
  logic [MW-1:0]   msum_d, mrow_d;
  logic [AW-1:0]   rd_addr_d;

  assign scol_d    = hcount_in[10:XW];
  assign srow_d    = vcount_in[9:YW];
  assign cell_ok_d = active_draw_in && (16'(scol_d) < 16'(COLS)) && (16'(srow_d) < 16'(ROWS));
  assign msum_d    = MW'(srow_d) + MW'(scroll_q);
  assign mrow_d    = (msum_d >= MW'(ROWS)) ? msum_d - MW'(ROWS) : msum_d;
  assign rd_addr_d = cell_ok_d ? AW'(mrow_d) * AW'(COLS) + AW'(scol_d) : '0;
  assign cur_hit_d = cell_ok_d && cursor_en_in && phase_q &&
                     (16'(scol_d) == 16'(cursor_col_in)) && (16'(srow_d) == 16'(cursor_row_in));

  logic            wr_ready_d, wr_acc_d, wr_inrange_d, mem_we_d;
  logic [AW-1:0]   wr_addr_d, mem_wa_d;
  logic [15:0]     mem_wd_d;

  assign wr_ready_d   = (state_q == IDLE) && !clear_in;
  assign wr_acc_d     = wr_valid_in && wr_ready_d && !rst_in;
  assign wr_inrange_d = (16'(wr_col_in) < 16'(COLS)) && (16'(wr_row_in) < 16'(ROWS));
  assign wr_addr_d    = AW'(wr_row_in) * AW'(COLS) + AW'(wr_col_in);
  // Host and clear never write in the same cycle: host writes need IDLE
  assign mem_we_d     = !rst_in && ((state_q == CLEAR) || (wr_acc_d && wr_inrange_d));
  assign mem_wa_d     = (state_q == CLEAR) ? clr_addr_q : wr_addr_d;
  assign mem_wd_d     = (state_q == CLEAR) ? clr_data_q : wr_data_in;

  always_ff @(posedge clk_in) begin
    if (mem_we_d) mem[mem_wa_d] <= mem_wd_d;
    rd_q <= mem[rd_addr_d];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      clr_addr_q <= '0;
      clr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (clear_in) begin
          state_q    <= CLEAR;
          busy_q     <= 1'b1;
          clr_addr_q <= '0;
          clr_data_q <= clear_data_in;
        end
        CLEAR: if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          clr_addr_q <= clr_addr_q + AW'(1);
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_err_q    <= 1'b0;
      scroll_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      wr_err_q <= wr_acc_d && !wr_inrange_d;
      if (frame_start_in) begin
        if (16'(scroll_row_in) < 16'(ROWS)) scroll_q <= scroll_row_in;
        if (blink_cnt_q == BW'(CURSOR_BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ok1_q    <= 1'b0;
      cur1_q   <= 1'b0;
      x1_q     <= '0;
      y1_q     <= '0;
      valid_q  <= 1'b0;
      cursor_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      code_q   <= '0;
      attr_q   <= '0;
    end else begin
      ok1_q    <= cell_ok_d;
      cur1_q   <= cur_hit_d;
      x1_q     <= hcount_in[XW-1:0];
      y1_q     <= vcount_in[YW-1:0];
      valid_q  <= ok1_q;
      cursor_q <= cur1_q;
      x_q      <= x1_q;
      y_q      <= y1_q;
      code_q   <= ok1_q ? rd_q[15:8] : 8'h00;
      attr_q   <= ok1_q ? rd_q[7:0]  : 8'h00;
    end
  end

  assign wr_ready_out   = wr_ready_d;
  assign wr_err_out     = wr_err_q;
  assign busy_out       = busy_q;
  assign valid_out      = valid_q;
  assign x_out          = x_q;
  assign y_out          = y_q;
  assign code_point_out = code_q;
  assign attribute_out  = attr_q;
  assign cursor_out     = cursor_q;
endmodule
